mem_responder: RTL
==================

Name: mem_responder

Overview:
- Word-addressed synchronous RAM on the far side of the datapath's MAR/MDR memory interface.
- Accepts Read/Write requests using the MAR address and the MDR write data.
- Returns read data on Mdata_out, which drives the MDR's Mdata_in.
- Multi-cycle latency with a 4-phase request/done handshake, so the future control unit can stall on memory.

Parameters:
- ADDR_WIDTH, 9, word address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- LATENCY, 2, edges from request acceptance to mem_done rising; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; one clock domain only.
- Read  input  1  read request level, held until mem_done is seen.
- Write  input  1  write request level, held until mem_done is seen.
- address  input  ADDR_WIDTH  word address, from MAR low bits.
- data_in  input  DATA_WIDTH  write data, from MDR.
- Mdata_out  output  DATA_WIDTH  read data to the MDR's Mdata_in.
- mem_done  output  1  access complete; held high until the request drops.
- busy  output  1  high in BUSY and DONE.
- mem_err  output  1  one-cycle pulse on a Read/Write conflict.

Behaviour:
- Reset (reset=0, async): state=IDLE, Mdata_out=0, mem_done=0, busy=0, mem_err=0, counter=0. RAM array is not cleared. An in-flight write is aborted and RAM is unchanged.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - Edge with exactly one of Read/Write high: latch address, data_in and op; counter <= LATENCY-1; go to BUSY.
  - Edge with both high: no accept; mem_err=1 for the next cycle; stay in IDLE.
  - Neither high: hold.
- BUSY:
  - counter!=0: decrement.
  - counter==0 and op=read: Mdata_out <= RAM[latched addr].
  - counter==0 and op=write: RAM[latched addr] <= latched data; Mdata_out unchanged.
  - After the access: mem_done <= 1; go to DONE.
  - Result: mem_done rises LATENCY edges after the accepting edge.
- DONE:
  - mem_done=1; Mdata_out holds.
  - When the latched op's request line is sampled low: go to IDLE, mem_done <= 0.
  - The other request line is ignored while in DONE.
- Back-to-back: a new request can be accepted no earlier than the edge after returning to IDLE. Minimum cycle is LATENCY+2 edges per access.
- address/data_in/Read/Write changes during BUSY are ignored; latched values are used.
- Request dropped early in BUSY: the access still completes, then DONE passes to IDLE on the next edge. mem_done is high for exactly one cycle.
- Read-after-write to the same address returns the new data.
- Address wraps naturally: width is fixed, so there is no out-of-range case.
- Mdata_out changes only on a read completion or on reset.

Test Plan:
1. Reset, then Write=1 addr=0x005 data=0xDEADBEEF, LATENCY=2 -> mem_done high 2 edges after accept; drop Write -> mem_done low next edge; Mdata_out stays 0.
2. Read=1 addr=0x005 -> mem_done rises after 2 edges with Mdata_out=0xDEADBEEF; address changed to 0x006 during BUSY -> still 0xDEADBEEF.
3. Read=1 and Write=1 together in IDLE -> mem_err pulses one cycle, busy stays 0, RAM unchanged (verify by a read).
4. Write addr=0x1FF data=0x12345678, then assert reset mid-BUSY -> outputs 0, state IDLE; a read of 0x1FF returns the prior contents, not 0x12345678.
5. Read held high through DONE for 5 cycles -> mem_done stays 1 and no second access occurs; release -> IDLE; immediate re-assert -> accepted the next edge.
6. LATENCY=1 build: write then read of 0x0A0 = 0xCAFEF00D -> each mem_done arrives 1 edge after accept; 3-edge minimum per access.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous RAM behind the MAR/MDR memory
// interface. A request is a Read or Write level held by the requester; the
// access completes LATENCY edges after acceptance, and mem_done stays high
// until the requester drops the request line that started the access
// (4-phase handshake).
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   Read       read request level
//   Write      write request level
//   address    word address (MAR low bits)
//   data_in    write data (from MDR)
//   Mdata_out  read data (to MDR Mdata_in); changes only on read completion or reset
//   mem_done   access complete, held until the request drops
//   busy       high while an access is in progress or waiting for release
//   mem_err    one-cycle pulse when Read and Write are both seen in IDLE
module mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdata_out,
  output logic                  mem_done,
  output logic                  busy,
  output logic                  mem_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    op_wr, op_wr_d;
  logic [DATA_WIDTH-1:0]   dout_d;
  logic                    done_d, busy_d, err_d;
  logic                    accept, ram_we;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_wr_d = op_wr;
    dout_d  = Mdata_out;
    done_d  = mem_done;
    busy_d  = busy;
    err_d   = 1'b0;
    accept  = 1'b0;
    ram_we  = 1'b0;
    case (state)
      IDLE: begin
        if (Read && Write) begin
          // Ambiguous request: refuse it and flag the conflict.
          err_d = 1'b1;
        end else if (Read || Write) begin
          accept  = 1'b1;
          op_wr_d = Write;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          if (op_wr) ram_we = 1'b1;
          else       dout_d = ram[addr_q];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Only the line that started the access releases the handshake.
        if (!(op_wr ? Write : Read)) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      Mdata_out <= '0;
      mem_done  <= 1'b0;
      busy      <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op_wr     <= op_wr_d;
      Mdata_out <= dout_d;
      mem_done  <= done_d;
      busy      <= busy_d;
      mem_err   <= err_d;
    end
  end

  // Request operands and RAM array carry no reset; the write strobe is only
  // possible in BUSY, so a reset during an access leaves the array untouched.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      wdata_q <= data_in;
    end
    if (ram_we) ram[addr_q] <= wdata_q;
  end

endmodule
